// File: rtl/umai_line_serializer.sv
// Serializes 512-bit upstream lines into 64-bit link flits: one header flit per packet, then 8 words per line.
// Optional macro UMAI_SER_PARITY_EN adds o_fparity (even XOR over o_fdata).
module umai_line_serializer #(
   parameter int         PKT_LINES = 4,
   parameter logic [7:0] HDR_ID    = 8'hA5
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_line_avail,
   output logic         o_line_pop,
   input  logic [511:0] i_line_data,
   output logic         o_fvalid,
   input  logic         i_fready,
   output logic [63:0]  o_fdata,
   output logic         o_fsop,
   output logic         o_feop,
   output logic         o_busy
`ifdef UMAI_SER_PARITY_EN
   ,
   output logic         o_fparity
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_WAIT = 2'd3;

   localparam logic [7:0]  LAST_LINE   = 8'(PKT_LINES - 1);
   localparam logic [15:0] PKT_LINES_W = 16'(PKT_LINES);
   localparam logic [2:0]  LAST_IDX    = 3'd7;

`ifdef UMAI_SER_PARITY_EN
   function automatic logic parity64(input logic [63:0] d);
      return ^d;
   endfunction
`endif

   logic [1:0]   state_r, state_s;
   logic [2:0]   idx_r, idx_s;
   logic [7:0]   line_cnt_r, line_cnt_s;
   logic [7:0]   seq_r, seq_s;
   logic [511:0] hold_r, hold_s;
   logic         pop_s;
   logic         hs_s;

   logic         fvalid_r, fvalid_s;
   logic [63:0]  fdata_r, fdata_s;
   logic         fsop_r, fsop_s;
   logic         feop_r, feop_s;
   logic         busy_r, busy_s;
`ifdef UMAI_SER_PARITY_EN
   logic         fparity_r;
`endif

   assign hs_s = fvalid_r & i_fready;

   // Next-state logic: a pop always coincides with the hold register being free.
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      line_cnt_s = line_cnt_r;
      seq_s      = seq_r;
      hold_s     = hold_r;
      pop_s      = 1'b0;
      if (i_rst) begin
         pop_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_line_avail) begin
                  pop_s   = 1'b1;
                  hold_s  = i_line_data;
                  idx_s   = 3'd0;
                  state_s = ST_HDR;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_HDR: begin
               if (hs_s) begin
                  idx_s   = 3'd0;
                  state_s = ST_DATA;
               end else begin
                  state_s = ST_HDR;
               end
            end
            ST_DATA: begin
               if (hs_s && (idx_r == LAST_IDX)) begin
                  idx_s = 3'd0;
                  if (line_cnt_r == LAST_LINE) begin
                     line_cnt_s = 8'd0;
                     seq_s      = seq_r + 8'd1;
                     state_s    = ST_IDLE;
                  end else if (i_line_avail) begin
                     pop_s      = 1'b1;
                     hold_s     = i_line_data;
                     line_cnt_s = line_cnt_r + 8'd1;
                     state_s    = ST_DATA;
                  end else begin
                     state_s = ST_WAIT;
                  end
               end else if (hs_s) begin
                  idx_s = idx_r + 3'd1;
               end else begin
                  state_s = ST_DATA;
               end
            end
            ST_WAIT: begin
               if (i_line_avail) begin
                  pop_s      = 1'b1;
                  hold_s     = i_line_data;
                  idx_s      = 3'd0;
                  line_cnt_s = line_cnt_r + 8'd1;
                  state_s    = ST_DATA;
               end else begin
                  state_s = ST_WAIT;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Flit outputs are precomputed from next state so they leave registers directly.
   always_comb begin
      fvalid_s = (state_s == ST_HDR) || (state_s == ST_DATA);
      fsop_s   = (state_s == ST_HDR);
      feop_s   = (state_s == ST_DATA) && (idx_s == LAST_IDX) && (line_cnt_s == LAST_LINE);
      busy_s   = (state_s != ST_IDLE);
      case (state_s)
         ST_HDR:  fdata_s = {HDR_ID, seq_s, PKT_LINES_W, 32'h0000_0000};
         ST_DATA: fdata_s = hold_s[{idx_s, 6'd0} +: 64];
         default: fdata_s = 64'h0;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r    <= ST_IDLE;
         idx_r      <= 3'd0;
         line_cnt_r <= 8'd0;
         seq_r      <= 8'd0;
         hold_r     <= 512'd0;
      end else begin
         state_r    <= state_s;
         idx_r      <= idx_s;
         line_cnt_r <= line_cnt_s;
         seq_r      <= seq_s;
         hold_r     <= hold_s;
      end
   end

   // Registered link-side outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fvalid_r <= 1'b0;
         fdata_r  <= 64'h0;
         fsop_r   <= 1'b0;
         feop_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         fvalid_r <= fvalid_s;
         fdata_r  <= fdata_s;
         fsop_r   <= fsop_s;
         feop_r   <= feop_s;
         busy_r   <= busy_s;
      end
   end

`ifdef UMAI_SER_PARITY_EN
   // Parity tracks the flit register; fdata is zero whenever no flit is valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fparity_r <= 1'b0;
      end else begin
         fparity_r <= parity64(fdata_s);
      end
   end

   assign o_fparity = fparity_r;
`endif

   assign o_line_pop = pop_s;
   assign o_fvalid   = fvalid_r;
   assign o_fdata    = fdata_r;
   assign o_fsop     = fsop_r;
   assign o_feop     = feop_r;
   assign o_busy     = busy_r;

endmodule

// File: tb/tb_umai_line_serializer.sv
// Scoreboard bench for umai_line_serializer (PKT_LINES=4): back-to-back, backpressure, starvation, reset, seq wrap.
module tb_umai_line_serializer;

   typedef struct {
      logic [63:0] d;
      logic        sop;
      logic        eop;
   } flit_t;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_line_avail;
   logic         o_line_pop;
   logic [511:0] i_line_data;
   logic         o_fvalid;
   logic         i_fready;
   logic [63:0]  o_fdata;
   logic         o_fsop;
   logic         o_feop;
   logic         o_busy;
`ifdef UMAI_SER_PARITY_EN
   logic         o_fparity;
`endif

   flit_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;
   int pop_total = 0;
   int rd_ptr = 0;
   int lim = 0;
   int cyc = 0;
   int sop_cyc = 0;
   int eop_cyc = 0;
   logic pop_pend = 1'b0;

   function automatic logic [63:0] line_word(input int k, input int w);
      logic [63:0] r;
      if (k == 0 && w == 0) r = 64'h1;
      else if (k == 0 && w == 1) r = 64'h3;
      else r = {16'hBEEF, 8'(w), 24'(k), 16'(k * 8 + w)};
      return r;
   endfunction

   function automatic logic [511:0] mk_line(input int k);
      logic [511:0] l;
      l = 512'd0;
      for (int w = 0; w < 8; w++) l[64*w +: 64] = line_word(k, w);
      return l;
   endfunction

   assign i_line_avail = (rd_ptr < lim);
   assign i_line_data  = mk_line(rd_ptr);

   umai_line_serializer #(.PKT_LINES(4), .HDR_ID(8'hA5)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_line_avail(i_line_avail),
      .o_line_pop(o_line_pop),
      .i_line_data(i_line_data),
      .o_fvalid(o_fvalid),
      .i_fready(i_fready),
      .o_fdata(o_fdata),
      .o_fsop(o_fsop),
      .o_feop(o_feop),
      .o_busy(o_busy)
`ifdef UMAI_SER_PARITY_EN
      ,
      .o_fparity(o_fparity)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic push_pkt(input int seq, input int first_line);
      flit_t f;
      f.d = {8'hA5, 8'(seq), 16'd4, 32'h0};
      f.sop = 1'b1;
      f.eop = 1'b0;
      exp_q.push_back(f);
      for (int l = 0; l < 4; l++) begin
         for (int w = 0; w < 8; w++) begin
            f.d = line_word(first_line + l, w);
            f.sop = 1'b0;
            f.eop = (l == 3) && (w == 7);
            exp_q.push_back(f);
         end
      end
   endtask

   task automatic wait_hs(input int target, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge i_clk); #1;
         if (hs_cnt >= target) return;
      end
      chk("wait_hs_timeout", 64'(hs_cnt), 64'(target));
   endtask

   task automatic wait_empty(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge i_clk); #1;
         if (exp_q.size() == 0) return;
      end
      chk("wait_empty_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   always @(posedge i_clk) begin
      cyc <= cyc + 1;
      if (pop_pend) rd_ptr <= rd_ptr + 1;
   end

   // Monitor: sample on the falling edge, score each accepted flit.
   always @(negedge i_clk) begin
      flit_t e;
      pop_pend = o_line_pop;
      if (o_line_pop === 1'b1) pop_total++;
      if (o_fvalid === 1'b1 && i_fready === 1'b1) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_flit", o_fdata, 64'h0);
         end else begin
            e = exp_q.pop_front();
            chk("fdata", o_fdata, e.d);
            chk("fsop", 64'(o_fsop), 64'(e.sop));
            chk("feop", 64'(o_feop), 64'(e.eop));
`ifdef UMAI_SER_PARITY_EN
            chk("fparity", 64'(o_fparity), 64'(^e.d));
`endif
            if (e.sop) sop_cyc = cyc;
            if (e.eop) eop_cyc = cyc;
         end
      end
   end

   initial begin
      int base;
      i_rst = 1'b1;
      i_fready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_fvalid", 64'(o_fvalid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_fsop", 64'(o_fsop), 64'd0);
      chk("rst_feop", 64'(o_feop), 64'd0);
      lim = 4;
      #1;
      chk("rst_no_pop", 64'(o_line_pop), 64'd0);
      @(posedge i_clk); #1;
      chk("rst_fvalid2", 64'(o_fvalid), 64'd0);

      // Back-to-back single packet, seq 0, lines 0..3.
      push_pkt(0, 0);
      i_rst = 1'b0;
      wait_empty(200);
      chk("b2b_sop_to_eop", 64'(eop_cyc - sop_cyc), 64'd32);
      chk("b2b_pops", 64'(pop_total), 64'd4);

      // Backpressure on data idx 3 of line 4.
      @(posedge i_clk); #1;
      base = hs_cnt;
      push_pkt(1, 4);
      lim = 8;
      wait_hs(base + 4, 100);
      i_fready = 1'b0;
      repeat (5) begin
         @(posedge i_clk); #1;
         chk("bp_fvalid", 64'(o_fvalid), 64'd1);
         chk("bp_fdata", o_fdata, line_word(4, 3));
         chk("bp_no_pop", 64'(o_line_pop), 64'd0);
      end
      i_fready = 1'b1;
      wait_empty(200);

      // Starvation after first line of packet seq 2.
      @(posedge i_clk); #1;
      base = hs_cnt;
      push_pkt(2, 8);
      lim = 9;
      wait_hs(base + 9, 100);
      repeat (3) begin
         chk("wait_fvalid", 64'(o_fvalid), 64'd0);
         chk("wait_busy", 64'(o_busy), 64'd1);
         @(posedge i_clk); #1;
      end
      lim = 12;
      wait_empty(200);
      chk("starve_pops", 64'(pop_total), 64'd12);

      // Reset while data idx 5 of line 12 is presented.
      @(posedge i_clk); #1;
      base = hs_cnt;
      push_pkt(3, 12);
      lim = 13;
      wait_hs(base + 6, 100);
      chk("pre_rst_fdata", o_fdata, line_word(12, 5));
      i_fready = 1'b0;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      chk("midrst_fvalid", 64'(o_fvalid), 64'd0);
      chk("midrst_busy", 64'(o_busy), 64'd0);
      chk("midrst_feop", 64'(o_feop), 64'd0);
      exp_q.delete();
      i_rst = 1'b0;
      i_fready = 1'b1;

      // 257 packets after reset: header seq 0..255 then 0.
      for (int k = 0; k < 257; k++) push_pkt(k, 13 + 4 * k);
      lim = 13 + 4 * 257;
      wait_empty(12000);
      chk("total_pops", 64'(pop_total), 64'(13 + 4 * 257));
      repeat (2) @(posedge i_clk);
      #1;
      chk("final_idle", 64'(o_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
